regbank_write_sequencer: RTL
============================

// Module: regbank_write_sequencer
// PURPOSE
// - Initiator side of the register-bank write port: accepts writeback requests from execute/memory
//   stages, sequences them into single-cycle enable/control pulses for the register bank.
// - Tracks privileged mode, stalls loads until memory data returns, and raises faults on illegal traps.
// PARAMETERS
// - REGISTER_LENGTH  32     data width of ALU/memory/SP values
// - ADDR_WIDTH       32     width of new_PC
// - TIMEOUT_CYCLES   255    max cycles in WAIT_MEM before a load faults (MEM_TIMEOUT_EN only)
// PORTS
// - slow_clock        in   1    single clock; all state updates on posedge
// - reset             in   1    synchronous, active-low (0 = reset)
// - req_valid         in   1    writeback request present
// - req_ready         out  1    request accepted this cycle when req_valid & req_ready
// - req_kind          in   3    0=PC/SP only, 1=ALU, 3=LOAD, 4=SYSCALL, 5=SYSRET, 6=CPXR
// - req_dest          in   4    destination register index
// - req_alu_result    in   REGISTER_LENGTH  ALU result / syscall number
// - req_new_PC        in   ADDR_WIDTH       next PC
// - req_new_SP        in   REGISTER_LENGTH  next SP
// - mem_data_valid    in   1    load data present on mem_data
// - mem_data          in   REGISTER_LENGTH  load data
// - enable            out  1    register-bank write strobe (one-cycle pulse)
// - control           out  3    register-bank control code
// - register_Dest     out  4    destination index to bank
// - ALU_result, data_from_memory, new_SP  out REGISTER_LENGTH; new_PC out ADDR_WIDTH
// - privileged        out  1    1 while in OS mode
// - fault             out  1    one-cycle pulse on illegal trap or load timeout
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=IDLE; enable=0, control=0, register_Dest=0, all data outputs 0,
//   privileged=0, fault=0, req_ready=0 during reset cycle, 1 on first cycle after.
// - States: IDLE, ISSUE, WAIT_MEM, FAULT.
// - IDLE: req_ready=1. On accept, latch all req_* fields; kind 3 -> WAIT_MEM, else -> ISSUE.
// - ISSUE: enable=1 for exactly one cycle with control=latched kind and latched operands; req_ready=0;
//   next state IDLE. Accept-to-enable latency = 1 cycle; back-to-back requests: one per 2 cycles.
// - WAIT_MEM: req_ready=0; on mem_data_valid latch mem_data into data_from_memory -> ISSUE with control=3.
//   mem_data_valid in the same cycle as accept is ignored (data must arrive >=1 cycle after accept).
// - Illegal traps: SYSCALL while privileged=1, SYSRET while privileged=0, or kind in {2,7}
//   -> FAULT: fault=1 one cycle, enable=1 with control=0 (advance PC/SP only), then IDLE.
// - privileged sets on ISSUE of control=4, clears on ISSUE of control=5; otherwise holds.
// - Outputs other than enable/fault hold last value when enable=0; enable is never high in IDLE/WAIT_MEM.
// - reset==0 in any state (incl. WAIT_MEM, ISSUE) aborts immediately: no enable pulse for the pending request.
// - req_* inputs are don't-care unless req_valid & req_ready.
// CONFIGURATION
// - MEM_TIMEOUT_EN defined: 8-bit-or-wider counter clears on WAIT_MEM entry, increments each
//   WAIT_MEM cycle without mem_data_valid; reaching TIMEOUT_CYCLES -> FAULT (control=0 pulse, fault=1).
//   mem_data_valid on the same cycle as terminal count wins (normal load).
// - MEM_TIMEOUT_EN undefined: no counter; WAIT_MEM waits indefinitely; fault only from illegal traps.
// TESTING
// - ALU: kind=1, dest=2, alu=0x1234, PC=0x10 -> next cycle enable=1, control=1, register_Dest=2, ALU_result=0x1234, new_PC=0x10.
// - LOAD: kind=3, dest=4; mem_data_valid after 5 cycles with 0xCAFE -> enable=1, control=3, data_from_memory=0xCAFE 1 cycle later.
// - Trap pair: SYSCALL alu=7 -> control=4, privileged=1; then SYSRET -> control=5, privileged=0.
// - Illegal: SYSRET with privileged=0 -> fault=1 and enable=1 control=0 same cycle; privileged stays 0.
// - Reset mid-load: reset=0 during WAIT_MEM -> no enable pulse, all outputs 0, req_ready=1 after release.
// - MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4: LOAD with no mem_data_valid -> fault=1 after 4 WAIT_MEM cycles, control=0.

Source files
------------

// File: rtl/regbank_write_sequencer.sv
// Writeback sequencer: accept-to-enable 1 cycle (loads: 1 cycle after mem_data_valid); req_ready low outside IDLE.
// Optional MEM_TIMEOUT_EN: a load waiting TIMEOUT_CYCLES without data faults with a PC/SP-only write.
module regbank_write_sequencer #(
  parameter int REGISTER_LENGTH = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       slow_clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [2:0]                 req_kind,
  input  logic [3:0]                 req_dest,
  input  logic [REGISTER_LENGTH-1:0] req_alu_result,
  input  logic [ADDR_WIDTH-1:0]      req_new_PC,
  input  logic [REGISTER_LENGTH-1:0] req_new_SP,
  input  logic                       mem_data_valid,
  input  logic [REGISTER_LENGTH-1:0] mem_data,
  output logic                       enable,
  output logic [2:0]                 control,
  output logic [3:0]                 register_Dest,
  output logic [REGISTER_LENGTH-1:0] ALU_result,
  output logic [REGISTER_LENGTH-1:0] data_from_memory,
  output logic [ADDR_WIDTH-1:0]      new_PC,
  output logic [REGISTER_LENGTH-1:0] new_SP,
  output logic                       privileged,
  output logic                       fault
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_MEM, FAULT} state_t;

  localparam logic [2:0] KIND_LOAD   = 3'd3;
  localparam logic [2:0] KIND_SYSCALL = 3'd4;
  localparam logic [2:0] KIND_SYSRET = 3'd5;

  state_t                     state;
  logic [3:0]                 lat_dest;
  logic [REGISTER_LENGTH-1:0] lat_alu;
  logic [ADDR_WIDTH-1:0]      lat_pc;
  logic [REGISTER_LENGTH-1:0] lat_sp;
  logic                       illegal;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;
`endif

  assign illegal = (req_kind == 3'd2) || (req_kind == 3'd7) ||
                   ((req_kind == KIND_SYSCALL) && privileged) ||
                   ((req_kind == KIND_SYSRET) && !privileged);

  always_ff @(posedge slow_clock) begin
    if (!reset) begin
      state            <= IDLE;
      req_ready        <= 1'b0;
      enable           <= 1'b0;
      fault            <= 1'b0;
      control          <= '0;
      register_Dest    <= '0;
      ALU_result       <= '0;
      data_from_memory <= '0;
      new_PC           <= '0;
      new_SP           <= '0;
      privileged       <= 1'b0;
      lat_dest         <= '0;
      lat_alu          <= '0;
      lat_pc           <= '0;
      lat_sp           <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt         <= '0;
`endif
    end else begin
      enable <= 1'b0;
      fault  <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            lat_dest  <= req_dest;
            lat_alu   <= req_alu_result;
            lat_pc    <= req_new_PC;
            lat_sp    <= req_new_SP;
            if (illegal) begin
              // Trap rejected: still advance PC/SP so the core does not re-execute it
              state         <= FAULT;
              fault         <= 1'b1;
              enable        <= 1'b1;
              control       <= 3'd0;
              register_Dest <= req_dest;
              new_PC        <= req_new_PC;
              new_SP        <= req_new_SP;
            end else if (req_kind == KIND_LOAD) begin
              state <= WAIT_MEM;
`ifdef MEM_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              state         <= ISSUE;
              enable        <= 1'b1;
              control       <= req_kind;
              register_Dest <= req_dest;
              ALU_result    <= req_alu_result;
              new_PC        <= req_new_PC;
              new_SP        <= req_new_SP;
              if (req_kind == KIND_SYSCALL) privileged <= 1'b1;
              if (req_kind == KIND_SYSRET)  privileged <= 1'b0;
            end
          end
        end
        ISSUE, FAULT: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        WAIT_MEM: begin
          // Data arriving on the terminal-count cycle takes priority over the timeout
          if (mem_data_valid) begin
            state            <= ISSUE;
            enable           <= 1'b1;
            control          <= KIND_LOAD;
            data_from_memory <= mem_data;
            register_Dest    <= lat_dest;
            ALU_result       <= lat_alu;
            new_PC           <= lat_pc;
            new_SP           <= lat_sp;
          end
`ifdef MEM_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state         <= FAULT;
            fault         <= 1'b1;
            enable        <= 1'b1;
            control       <= 3'd0;
            register_Dest <= lat_dest;
            new_PC        <= lat_pc;
            new_SP        <= lat_sp;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
